// File: rtl/column_render_scheduler.sv
// rtl/column_render_scheduler.sv - per-column ceiling/wall/floor sequencer for the shared line drawer
module column_render_scheduler #(
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [17:0] CEIL_COLOUR  = 18'h0_0FFF,
  parameter logic [17:0] FLOOR_COLOUR = 18'h0_7C00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        busy,
  output logic        col_req,
  output logic [7:0]  col_x,
  input  logic        col_valid,
  input  logic [6:0]  col_top,
  input  logic [6:0]  col_bottom,
  input  logic [17:0] col_colour,
  output logic        line_start,
  input  logic        line_done,
  output logic [7:0]  line_x,
  output logic [6:0]  line_min_y,
  output logic [6:0]  line_max_y,
  output logic [17:0] line_colour
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_REQ        = 4'd1;
  localparam logic [3:0] S_CEIL       = 4'd2;
  localparam logic [3:0] S_WAIT_CEIL  = 4'd3;
  localparam logic [3:0] S_WALL       = 4'd4;
  localparam logic [3:0] S_WAIT_WALL  = 4'd5;
  localparam logic [3:0] S_FLOOR      = 4'd6;
  localparam logic [3:0] S_WAIT_FLOOR = 4'd7;
  localparam logic [3:0] S_NEXT       = 4'd8;
  localparam logic [3:0] S_DONE       = 4'd9;

  localparam logic [7:0] LAST_X = 8'(SCREEN_W - 1);
  localparam logic [6:0] LAST_Y = 7'(SCREEN_H - 1);
  localparam logic [6:0] MID_Y  = 7'(SCREEN_H / 2);

  logic [3:0]  state;
  logic [6:0]  top_q;
  logic [6:0]  bot_q;
  logic [17:0] wall_colour;
  logic        wall_empty;
  logic [6:0]  bot_clamped;
  logic        cap_empty;

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign col_req = (state == S_REQ);

  // Clamp the incoming bottom row and flag an empty wall before capture
  always_comb begin
    bot_clamped = (col_bottom > LAST_Y) ? LAST_Y : col_bottom;
    cap_empty   = (col_top > bot_clamped);
  end

  // Frame sequencer: one column request, then up to three drawer segments per column
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      col_x       <= 8'd0;
      top_q       <= 7'd0;
      bot_q       <= 7'd0;
      wall_colour <= 18'd0;
      wall_empty  <= 1'b0;
      line_start  <= 1'b0;
      line_x      <= 8'd0;
      line_min_y  <= 7'd0;
      line_max_y  <= 7'd0;
      line_colour <= 18'd0;
    end else begin
      line_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            col_x <= 8'd0;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (col_valid) begin
            wall_colour <= col_colour;
            wall_empty  <= cap_empty;
            // An empty wall splits the column evenly so ceiling and floor still cover it
            if (cap_empty) begin
              top_q <= MID_Y;
              bot_q <= MID_Y - 7'd1;
            end else begin
              top_q <= col_top;
              bot_q <= bot_clamped;
            end
            state <= S_CEIL;
          end
        end
        S_CEIL: begin
          if (top_q == 7'd0) begin
            state <= S_WALL;
          end else begin
            line_start  <= 1'b1;
            line_x      <= col_x;
            line_min_y  <= 7'd0;
            line_max_y  <= top_q - 7'd1;
            line_colour <= CEIL_COLOUR;
            state       <= S_WAIT_CEIL;
          end
        end
        S_WAIT_CEIL: begin
          if (line_done) state <= S_WALL;
        end
        S_WALL: begin
          if (wall_empty) begin
            state <= S_FLOOR;
          end else begin
            line_start  <= 1'b1;
            line_x      <= col_x;
            line_min_y  <= top_q;
            line_max_y  <= bot_q;
            line_colour <= wall_colour;
            state       <= S_WAIT_WALL;
          end
        end
        S_WAIT_WALL: begin
          if (line_done) state <= S_FLOOR;
        end
        S_FLOOR: begin
          if (bot_q == LAST_Y) begin
            state <= S_NEXT;
          end else begin
            line_start  <= 1'b1;
            line_x      <= col_x;
            line_min_y  <= bot_q + 7'd1;
            line_max_y  <= LAST_Y;
            line_colour <= FLOOR_COLOUR;
            state       <= S_WAIT_FLOOR;
          end
        end
        S_WAIT_FLOOR: begin
          if (line_done) state <= S_NEXT;
        end
        S_NEXT: begin
          if (col_x == LAST_X) begin
            state <= S_DONE;
          end else begin
            col_x <= col_x + 8'd1;
            state <= S_REQ;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_column_render_scheduler.sv
// tb/tb_column_render_scheduler.sv - scoreboard bench for column_render_scheduler
module tb_column_render_scheduler;

  localparam logic [17:0] CEIL_C  = 18'h0_0FFF;
  localparam logic [17:0] FLOOR_C = 18'h0_7C00;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic        busy;
  logic        col_req;
  logic [7:0]  col_x;
  logic        col_valid;
  logic [6:0]  col_top;
  logic [6:0]  col_bottom;
  logic [17:0] col_colour;
  logic        line_start;
  logic        line_done;
  logic [7:0]  line_x;
  logic [6:0]  line_min_y;
  logic [6:0]  line_max_y;
  logic [17:0] line_colour;
  logic        drawer_done;
  logic        manual_done;

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  mn;
    logic [6:0]  mx;
    logic [17:0] c;
    logic        wall;
  } seg_t;

  seg_t        exp_q[$];
  seg_t        cur;
  logic [6:0]  tbl_top[160];
  logic [6:0]  tbl_bot[160];
  logic [17:0] tbl_col[160];
  int          vectors = 0;
  int          miscompares = 0;
  int          hs_total = 0;
  int          hs_base = 0;
  int          done_total = 0;
  int          start_total = 0;
  int          drw_delay = 2;
  int          dly;
  bit          stall_en = 1'b0;
  bit          stalled = 1'b0;
  int          base_d;
  int          base_s;
  int          n;

  assign line_done = drawer_done | manual_done;

  always #5 clock = ~clock;

  column_render_scheduler dut (
    .clock(clock), .reset(reset), .start(start), .done(done), .busy(busy),
    .col_req(col_req), .col_x(col_x), .col_valid(col_valid), .col_top(col_top),
    .col_bottom(col_bottom), .col_colour(col_colour), .line_start(line_start),
    .line_done(line_done), .line_x(line_x), .line_min_y(line_min_y),
    .line_max_y(line_max_y), .line_colour(line_colour)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void push_column(input logic [7:0] x, input logic [6:0] t,
                                      input logic [6:0] b, input logic [17:0] c);
    logic [6:0] bc;
    bc = (b > 7'd119) ? 7'd119 : b;
    if (t > bc) begin
      exp_q.push_back('{x, 7'd0, 7'd59, CEIL_C, 1'b0});
      exp_q.push_back('{x, 7'd60, 7'd119, FLOOR_C, 1'b0});
    end else begin
      if (t != 7'd0) exp_q.push_back('{x, 7'd0, t - 7'd1, CEIL_C, 1'b0});
      exp_q.push_back('{x, t, bc, c, 1'b1});
      if (bc != 7'd119) exp_q.push_back('{x, bc + 7'd1, 7'd119, FLOOR_C, 1'b0});
    end
  endfunction

  task automatic fill_table();
    for (int i = 0; i < 160; i++) begin
      tbl_top[i] = 7'($urandom_range(0, 127));
      tbl_bot[i] = 7'($urandom_range(0, 127));
      tbl_col[i] = 18'($urandom);
    end
    tbl_top[0] = 7'd40; tbl_bot[0] = 7'd79;  tbl_col[0] = 18'h3F000;
    tbl_top[1] = 7'd0;  tbl_bot[1] = 7'd119; tbl_col[1] = 18'h12345;
    tbl_top[2] = 7'd60; tbl_bot[2] = 7'd20;  tbl_col[2] = 18'h2AAAA;
    tbl_top[3] = 7'd10; tbl_bot[3] = 7'd127; tbl_col[3] = 18'h05555;
  endtask

  task automatic run_frame();
    int  bd;
    bit  got;
    hs_base = hs_total;
    bd = done_total;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    got = 1'b0;
    for (int c = 0; c < 40000 && !got; c++) begin
      @(negedge clock);
      start = (c == 300);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("frame_done_seen", got, 1);
    check("frame_handshakes", hs_total - hs_base, 160);
    check("frame_queue_empty", exp_q.size(), 0);
    @(negedge clock);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("frame_done_pulses", done_total - bd, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; col_valid = 1'b0; col_top = 7'd0; col_bottom = 7'd0;
    col_colour = 18'd0; drawer_done = 1'b0; manual_done = 1'b0;

    fork
      forever begin
        @(negedge clock);
        if (done) done_total++;
        if (line_start) start_total++;
      end
      forever begin
        @(negedge clock);
        if (reset) begin
          exp_q.delete();
          col_valid = 1'b0;
        end else if (col_req) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          check("col_x_order", col_x, hs_total - hs_base);
          check("prev_column_drained", exp_q.size(), 0);
          col_top    = tbl_top[col_x];
          col_bottom = tbl_bot[col_x];
          col_colour = tbl_col[col_x];
          push_column(col_x, tbl_top[col_x], tbl_bot[col_x], tbl_col[col_x]);
          col_valid = 1'b1;
          hs_total++;
          @(negedge clock);
          col_valid = 1'b0;
          check("col_req_released", col_req, 0);
        end else if (line_start) begin
          check("start_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("seg_x", line_x, cur.x);
            check("seg_min", line_min_y, cur.mn);
            check("seg_max", line_max_y, cur.mx);
            check("seg_colour", line_colour, cur.c);
            if (stall_en && cur.x == 8'd5 && cur.wall) begin
              stalled = 1'b1;
            end else begin
              dly = (drw_delay < 0) ? int'($urandom_range(0, 3)) : drw_delay;
              repeat (dly) @(negedge clock);
              check("seg_stable_min", line_min_y, cur.mn);
              check("seg_stable_max", line_max_y, cur.mx);
              check("seg_stable_colour", line_colour, cur.c);
              drawer_done = 1'b1;
              @(negedge clock);
              drawer_done = 1'b0;
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_col_req", col_req, 0);
    check("rst_col_x", col_x, 0);
    check("rst_line_start", line_start, 0);
    check("rst_line_x", line_x, 0);
    check("rst_line_min", line_min_y, 0);
    check("rst_line_max", line_max_y, 0);
    check("rst_line_colour", line_colour, 0);
    reset = 1'b0;
    @(negedge clock);

    drw_delay = 2;
    fill_table();
    run_frame();

    fill_table();
    tbl_top[5] = 7'd30;
    tbl_bot[5] = 7'd90;
    stall_en = 1'b1;
    stalled = 1'b0;
    hs_base = hs_total;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!stalled && n < 8000) begin
      @(negedge clock);
      n++;
    end
    check("stall_reached", stalled, 1);
    @(negedge clock);
    check("wait_wall_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_col_req", col_req, 0);
    check("abort_col_x", col_x, 0);
    check("abort_line_start", line_start, 0);
    check("abort_done", done, 0);
    check("abort_line_x", line_x, 0);
    check("abort_line_min", line_min_y, 0);
    check("abort_line_colour", line_colour, 0);
    @(negedge clock);
    reset = 1'b0;
    stall_en = 1'b0;
    stalled = 1'b0;
    base_d = done_total;
    base_s = start_total;
    manual_done = 1'b1;
    @(negedge clock);
    manual_done = 1'b0;
    repeat (20) @(negedge clock);
    check("late_done_no_start", start_total - base_s, 0);
    check("late_done_no_done", done_total - base_d, 0);
    check("late_done_idle", busy, 0);
    check("late_done_no_req", col_req, 0);

    drw_delay = -1;
    fill_table();
    run_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
